// File: rtl/carrier_gen_multi.sv
// -----------------------------------------------------------------------------
// carrier_gen_multi
//
// Multi-channel PWM carrier generator. NCH carriers of WIDTH bits count
// from one shared, shadow-buffered period in UP, DOWN, UP/DOWN or HOLD mode.
// Each channel starts from its own phase value. Each channel also produces a
// one-cycle mask-event pulse at the minimum and/or maximum of its carrier.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   en           1 = run, 0 = all carriers held at 0
//   period       requested period P; it becomes the active period Pa through
//                a shadow register
//   phase        per-channel start value, channel i at [i*WIDTH +: WIDTH]
//   count_mode   0 UP, 1 DOWN, 2 UPDOWN, 3 HOLD
//   mask_mode    0 none, 1 MIN, 2 MAX, 3 MINMAX
//   sync_in      resynchronise pulse (only when CARRIER_SYNC_EN is defined)
//   carrier      registered carrier values, channel i at [i*WIDTH +: WIDTH]
//   dir          registered per-channel direction, 0 UP, 1 DOWN
//   mask_event   registered one-cycle pulse when a carrier shows an extremum
//   period_load  one-cycle pulse when the active period changes value
//
// Optional feature macro: CARRIER_SYNC_EN (adds sync_in). The feature is
// disabled when the macro is undefined.
// -----------------------------------------------------------------------------
module carrier_gen_multi #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [WIDTH-1:0]     period,
    input  logic [NCH*WIDTH-1:0] phase,
    input  logic [1:0]           count_mode,
    input  logic [1:0]           mask_mode,
`ifdef CARRIER_SYNC_EN
    input  logic                 sync_in,
`endif
    output logic [NCH*WIDTH-1:0] carrier,
    output logic [NCH-1:0]       dir,
    output logic [NCH-1:0]       mask_event,
    output logic                 period_load
);

    // All channels share en and sync, so they always sit in the same state.
    // One state register therefore serves every channel.
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic [1:0] M_UP     = 2'd0;
    localparam logic [1:0] M_DOWN   = 2'd1;
    localparam logic [1:0] M_UPDOWN = 2'd2;
    localparam logic [1:0] M_HOLD   = 2'd3;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pa_q, pa_d;
    logic [WIDTH-1:0] c_q [NCH];
    logic [WIDTH-1:0] c_d [NCH];
    logic [NCH-1:0]   dir_q, dir_d;
    logic [NCH-1:0]   ev_q, ev_d;
    logic             pl_q, pl_d;

    logic [WIDTH-1:0] phase_ch [NCH];
    logic [WIDTH-1:0] start_c  [NCH];
    logic [WIDTH-1:0] run_c    [NCH];
    logic [NCH-1:0]   run_dir;
    logic [NCH-1:0]   start_dir;
    logic [WIDTH:0]   step_v;
    logic [WIDTH-1:0] lim_old, lim_new, lim_start, pa_next;
    logic             shadow;
    logic             sync_req;

`ifdef CARRIER_SYNC_EN
    assign sync_req = sync_in;
`else
    assign sync_req = 1'b0;
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign phase_ch[g]                 = phase[g*WIDTH +: WIDTH];
        assign carrier[g*WIDTH +: WIDTH]   = c_q[g];
    end

    assign dir         = dir_q;
    assign mask_event  = ev_q;
    assign period_load = pl_q;

    // Turning point L: one below the period for saw modes, the period itself
    // for the triangle. A zero period pins everything to 0.
    function automatic logic [WIDTH-1:0] limit_of(input logic [WIDTH-1:0] p,
                                                  input logic [1:0]       m);
        logic [WIDTH-1:0] l;
        if (p == '0)
            l = '0;
        else if (m == M_UPDOWN)
            l = p;
        else
            l = p - ONE;
        return l;
    endfunction

    // One counting step for a channel against limit l. Returns {dir, value}.
    // A value above l appears only after a mode change shrinks L. Such a
    // value is pulled back to l, so nothing beyond L is ever produced.
    function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] c,
                                            input logic             d,
                                            input logic [1:0]       m,
                                            input logic [WIDTH-1:0] l);
        logic [WIDTH-1:0] n;
        logic             nd;
        n  = c;
        nd = d;
        case (m)
            M_UP: begin
                nd = 1'b0;
                if (c > l)       n = l;
                else if (c == l) n = '0;
                else             n = c + ONE;
            end
            M_DOWN: begin
                nd = 1'b1;
                if (c > l)        n = l;
                else if (c == '0) n = l;
                else              n = c - ONE;
            end
            M_UPDOWN: begin
                if (c > l) begin
                    n  = l;
                    nd = 1'b1;
                end else if ((!d && (c < l)) || (d && (c == '0))) begin
                    // rising (or bouncing off the floor)
                    n  = c + ONE;
                    nd = (n >= l);
                end else begin
                    // falling (or bouncing off the peak)
                    n  = c - ONE;
                    nd = (n != '0);
                end
            end
            default: ;  // HOLD: frozen
        endcase
        return {nd, n};
    endfunction

    // Datapath: candidate start values and free-running next values.
    always_comb begin
        step_v    = '0;
        lim_old   = limit_of(pa_q, count_mode);
        lim_start = limit_of(period, count_mode);
        start_dir = {NCH{count_mode == M_DOWN}};
        run_dir   = dir_q;
        for (int i = 0; i < NCH; i++) begin
            start_c[i] = (phase_ch[i] > lim_start) ? lim_start : phase_ch[i];
            step_v     = step(c_q[i], dir_q[i], count_mode, lim_old);
            if (pa_q == '0) begin
                run_c[i] = '0;
            end else begin
                run_c[i]   = step_v[WIDTH-1:0];
                run_dir[i] = step_v[WIDTH];
            end
        end
        // Channel 0 returning to 0 is the safe point to swap in a new period.
        shadow  = (run_c[0] == '0);
        pa_next = shadow ? period : pa_q;
        lim_new = limit_of(pa_next, count_mode);
    end

    // FSM next-state and register inputs.
    always_comb begin
        state_d = state_q;
        pa_d    = pa_q;
        dir_d   = dir_q;
        ev_d    = '0;
        pl_d    = 1'b0;
        for (int i = 0; i < NCH; i++) c_d[i] = c_q[i];

        case (state_q)
            ST_OFF: begin
                pa_d  = period;
                dir_d = '0;
                for (int i = 0; i < NCH; i++) c_d[i] = '0;
                if (en) begin
                    state_d = ST_START;
                    dir_d   = start_dir;
                    for (int i = 0; i < NCH; i++) c_d[i] = start_c[i];
                end
            end
            default: begin
                if (!en) begin
                    // en low wins over everything, including sync
                    state_d = ST_OFF;
                    pa_d    = period;
                    dir_d   = '0;
                    for (int i = 0; i < NCH; i++) c_d[i] = '0;
                end else if (sync_req) begin
                    // Resync replaces any coincident shadow update.
                    // Only one period_load can result.
                    state_d = ST_START;
                    pa_d    = period;
                    pl_d    = (period != pa_q);
                    dir_d   = start_dir;
                    for (int i = 0; i < NCH; i++) c_d[i] = start_c[i];
                end else begin
                    state_d = ST_RUN;
                    dir_d   = run_dir;
                    for (int i = 0; i < NCH; i++) c_d[i] = run_c[i];
                    if (shadow) begin
                        pa_d = period;
                        pl_d = (period != pa_q);
                    end
                    // A shrinking period can leave another channel above the
                    // new L. Pull that channel back to L; the saw-up mode
                    // wraps it to 0 instead.
                    for (int i = 1; i < NCH; i++) begin
                        if (shadow && (count_mode != M_HOLD) && (c_d[i] > lim_new)) begin
                            c_d[i] = (count_mode == M_UP) ? '0 : lim_new;
                            if (count_mode == M_UPDOWN) dir_d[i] = 1'b1;
                        end
                    end
                    for (int i = 0; i < NCH; i++) begin
                        ev_d[i] = (count_mode != M_HOLD) && (pa_q != '0) &&
                                  ((mask_mode[0] && (c_d[i] == '0)) ||
                                   (mask_mode[1] && (c_d[i] == lim_new)));
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_OFF;
            pa_q    <= '0;
            dir_q   <= '0;
            ev_q    <= '0;
            pl_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) c_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pa_q    <= pa_d;
            dir_q   <= dir_d;
            ev_q    <= ev_d;
            pl_q    <= pl_d;
            for (int i = 0; i < NCH; i++) c_q[i] <= c_d[i];
        end
    end

endmodule

// File: doc/carrier_gen_multi.md
# carrier_gen_multi

Parametrised multi-channel PWM carrier generator, the successor of the single 16-bit carrier generator in the PWM subsystem. It produces NCH phase-shifted carriers of WIDTH bits from one shared, shadow-buffered period, in up, down or up/down mode, plus per-channel mask-event pulses. It feeds the PWM comparators and deadtime stages.

## Interface
- WIDTH, 16, carrier/period/phase width in bits (≥4)
- NCH, 4, number of carrier channels (1..16)
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  1 = run, 0 = carriers held at 0 (PWM off)
- period  in  WIDTH  requested period P, loaded into shadow (see Operation)
- phase  in  NCH*WIDTH  per-channel start value, channel i at [i*WIDTH +: WIDTH]
- count_mode  in  2  0 UP, 1 DOWN, 2 UPDOWN, 3 HOLD
- mask_mode  in  2  0 none, 1 MIN, 2 MAX, 3 MINMAX
- sync_in  in  1  resynchronise pulse (only with CARRIER_SYNC_EN)
- carrier  out  NCH*WIDTH  carrier values, registered
- dir  out  NCH  per-channel direction, 0 UP, 1 DOWN, registered
- mask_event  out  NCH  one-cycle pulse at extremum, registered
- period_load  out  1  one-cycle pulse when active period is updated

## Operation
- Active period Pa (internal register). Limit L = P−1 for UP/DOWN, Pa for UPDOWN.
- Per-channel states: OFF, START, RUN.
- OFF (en=0): carrier=0, dir=0, mask_event=0; Pa follows period every cycle. en=1 → START.
- START (one cycle): carrier[i] ← min(phase[i], L), dir ← 0 (DOWN mode: dir ← 1); no mask_event; → RUN.
- RUN, Pa=0: carriers hold 0, no events, no period_load.
- RUN, UP: c ← c+1; c=L → 0.
- RUN, DOWN: c ← c−1; c=0 → L.
- RUN, UPDOWN: dir=0: c ← c+1, dir ← 1 when next c = L; dir=1: c ← c−1, dir ← 0 when next c = 0.
- RUN, HOLD: carriers frozen, no events.
- mask_event[i] asserts in the same cycle carrier[i] shows 0 (MIN/MINMAX) or L (MAX/MINMAX), RUN only.
- Period shadow: while RUN, Pa ← period on the cycle channel 0's next value is 0; period_load pulses with it if value changed. Other channels whose next value exceeds new L are clamped to L (UP: wrap to 0).
- count_mode change in RUN: takes effect next cycle; out-of-range values clamped to L.
- Arithmetic is WIDTH-bit unsigned; no wrap beyond L is ever produced.

## Timing
- Reset (reset_n=0, asynchronous): carrier=0, dir=0, mask_event=0, period_load=0, Pa=0, all channels OFF; release is synchronous to clk.
- en sampled 1 at edge k (was 0): START at edge k (carrier=phase), first increment at edge k+1.
- en sampled 0: carriers 0 at the next edge; en low overrides sync_in.
- Events and carriers share the same register stage: zero latency between them.
- Reset mid-operation aborts immediately; no pending period_load survives.

## Configuration
- CARRIER_SYNC_EN defined: sync_in present; a 1-cycle pulse while RUN forces all channels to START on the next edge (phase reload, dir reset, Pa ← period). Coincident with a shadow update, sync wins, period_load pulses once.
- Not defined: sync_in port absent; channels align only on en rising edge.

## Test plan
- NCH=2, UPDOWN, period=4, phase={2,0}, MINMAX: ch0 0,1,2,3,4,3,2,1,0,1…; ch1 2,3,4,3,2,1,0…; mask_event at carrier 4 and 0 only.
- UP, period=5, MAX: carrier 0,1,2,3,4,0…; mask_event on every 4; DOWN mode: 4,3,2,1,0,4… with MIN events at 0.
- UPDOWN period 4→6 written while ch0 at 2 rising: Pa stays 4 until ch0 reaches 0, then period_load pulse, next peak is 6.
- phase=9 with period=4 UPDOWN: START value clamped to 4; period=0: carriers stay 0, no events.
- en deasserted mid-count: carriers 0 next edge; reset_n low mid-count: all outputs 0 without a clock edge.
- CARRIER_SYNC_EN: sync_in pulse with ch0 at 3: next edge ch0=phase[0], dir=0, counting resumes following edge.
